// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and LFSR helpers for the noise bank
package lfsr_pkg;
   typedef enum logic [1:0] {IDLE, FREE, BURST, DRAIN} fsm_t;
   // maximal-length feedback masks indexed by width
   localparam logic [31:0] DEFAULT_TAPS [4:32] = '{
      32'h0000_000C, 32'h0000_0014, 32'h0000_0030, 32'h0000_0060, 32'h0000_00B8,
      32'h0000_0110, 32'h0000_0240, 32'h0000_0500, 32'h0000_0E08, 32'h0000_1C80,
      32'h0000_3802, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,
      32'h0007_2000, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
      32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013, 32'h0900_0000,
      32'h1400_0000, 32'h2000_0029, 32'h4800_0000, 32'h8020_0003};
   function automatic logic [31:0] wmask(input int w);
      return (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
   endfunction
   function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps, input int w);
      return ((s << 1) | {31'd0, ^(s & taps & wmask(w))}) & wmask(w);
   endfunction
   function automatic logic [31:0] ch_seed(input logic [31:0] seed, input int i, input int w);
      logic [31:0] r;
      r = seed & wmask(w);
      for (int k = 0; k < i % w; k++) r = ((r << 1) | {31'd0, r[w-1]}) & wmask(w);
      return r;
   endfunction
endpackage

// File: rtl/lfsr_noise_bank_if.sv
// lfsr_noise_bank_if: valid/ready output stream carrying one word per channel
interface lfsr_noise_bank_if #(parameter int WIDTH = 16, parameter int NCH = 4);
   logic valid;
   logic ready;
   logic [NCH*WIDTH-1:0] data;
   modport master (output valid, output data, input ready);
   modport slave (input valid, input data, output ready);
endinterface

// File: rtl/lfsr_lane.sv
// lfsr_lane: one channel's Fibonacci LFSR state with load and step
module lfsr_lane import lfsr_pkg::*; #(
   parameter int WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEFAULT_TAPS[WIDTH]),
   parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] state
);
   always_ff @(posedge clk)
      if (rst) state <= RST_SEED;
      else if (load) state <= load_data;
      else if (step) state <= WIDTH'(lfsr_next(32'(state), 32'(TAPS), WIDTH));
   a_nonzero: assert property (@(posedge clk) disable iff (rst) state != '0);
endmodule

// File: rtl/lfsr_noise_bank.sv
// lfsr_noise_bank: multi-channel LFSR noise source with free-run/burst modes and a backpressured stream
module lfsr_noise_bank import lfsr_pkg::*; #(
   parameter int WIDTH = 16,
   parameter int NCH = 4,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(16'hB400),
   parameter logic [WIDTH-1:0] SEED = WIDTH'(16'hACE1),
   parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             start,
   input  logic             stop,
   input  logic [15:0]      burst_len,
   output logic             busy,
   output logic             done,
   input  logic             seed_valid,
   output logic             seed_ready,
   input  logic [CHW-1:0]   seed_ch,
   input  logic [WIDTH-1:0] seed_data,
   lfsr_noise_bank_if.master stream
);
   if (WIDTH < 4 || WIDTH > 32 || NCH < 1 || SEED == '0 || !TAPS[WIDTH-1]) begin : g_bad
      $error("lfsr_noise_bank: illegal parameter set");
   end
   fsm_t fsm, nxt;
   logic [15:0] remaining;
   logic ov, dn, step, seed_take;
   logic [NCH*WIDTH-1:0] od, states;
   assign busy = fsm != IDLE;
   assign seed_ready = (fsm == IDLE) & ~rst;
   assign seed_take = seed_valid & seed_ready;
   assign step = en & (fsm == FREE | fsm == BURST) & (~ov | stream.ready);
   assign stream.valid = ov;
   assign stream.data = od;
   // a zero seed would lock the lane, so it falls back to the channel's reset seed
   for (genvar i = 0; i < NCH; i++) begin : g_lane
      localparam logic [WIDTH-1:0] CS = WIDTH'(ch_seed(32'(SEED), i, WIDTH));
      lfsr_lane #(.WIDTH(WIDTH), .TAPS(TAPS), .RST_SEED(CS)) u_lane (
         .clk(clk),
         .rst(rst),
         .load(seed_take & (seed_ch == CHW'(i))),
         .step(step),
         .load_data((seed_data == '0) ? CS : seed_data),
         .state(states[i*WIDTH +: WIDTH])
      );
   end
   always_comb begin
      nxt = fsm;
      dn = 1'b0;
      unique case (fsm)
         IDLE: if (start) begin
            nxt = mode ? ((burst_len != 16'd0) ? BURST : IDLE) : FREE;
            dn = mode & (burst_len == 16'd0);
         end
         FREE: nxt = stop ? DRAIN : FREE;
         BURST: nxt = (stop | (step & remaining == 16'd1)) ? DRAIN : BURST;
         DRAIN: if (~ov | stream.ready) begin
            nxt = IDLE;
            dn = 1'b1;
         end
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         fsm <= IDLE;
         remaining <= 16'd0;
         ov <= 1'b0;
         od <= '0;
         done <= 1'b0;
      end else begin
         fsm <= nxt;
         done <= dn;
         remaining <= (fsm == IDLE & start & mode) ? burst_len : (fsm == BURST & step) ? remaining - 16'd1 : remaining;
         if (step) begin
            od <= states;
            ov <= 1'b1;
         end else if (stream.ready) ov <= 1'b0;
      end
endmodule

// File: tb/tb_lfsr_noise_bank.sv
// tb_lfsr_noise_bank: directed stimulus with a stream-level LFSR model checked every valid cycle
module tb_lfsr_noise_bank;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic a_en, a_mode, a_start, a_stop, a_busy, a_done, a_sv, a_sr;
   logic [15:0] a_blen, a_sd;
   logic [1:0] a_sch;
   logic b_en, b_mode, b_start, b_stop, b_busy, b_done, b_sv, b_sr;
   logic [15:0] b_blen;
   logic [3:0] b_sd;
   logic [1:0] b_sch;
   lfsr_noise_bank_if #(.WIDTH(16), .NCH(4)) a_if();
   lfsr_noise_bank_if #(.WIDTH(4), .NCH(3)) b_if();
   lfsr_noise_bank u_a (
      .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .start(a_start), .stop(a_stop),
      .burst_len(a_blen), .busy(a_busy), .done(a_done), .seed_valid(a_sv), .seed_ready(a_sr),
      .seed_ch(a_sch), .seed_data(a_sd), .stream(a_if)
   );
   lfsr_noise_bank #(.WIDTH(4), .NCH(3), .TAPS(4'hC), .SEED(4'h1)) u_b (
      .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .start(b_start), .stop(b_stop),
      .burst_len(b_blen), .busy(b_busy), .done(b_done), .seed_valid(b_sv), .seed_ready(b_sr),
      .seed_ch(b_sch), .seed_data(b_sd), .stream(b_if)
   );
   int checks = 0, errors = 0, beats = 0, dones = 0;
   logic [15:0] m [4];
   logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask
   function automatic logic [15:0] rol(input logic [15:0] s, input int r);
      return (r == 0) ? s : ((s << r) | (s >> (16 - r)));
   endfunction
   // the stream of accepted words per channel is the tap-parity shift sequence
   function automatic logic [15:0] adv(input logic [15:0] s);
      return {s[14:0], 1'($countones(s & 16'hB400) % 2)};
   endfunction
   always @(negedge clk)
      if (rst) for (int i = 0; i < 4; i++) m[i] = rol(16'hACE1, i);
      else begin
         if (a_if.valid) chk("stream", a_if.data, {m[3], m[2], m[1], m[0]});
         if (a_if.valid & a_if.ready) begin
            beats++;
            for (int i = 0; i < 4; i++) m[i] = adv(m[i]);
         end
         if (a_done) dones++;
      end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_idle(input int maxc);
      int n = 0;
      while (a_busy && n < maxc) begin
         tick(1);
         n++;
      end
      chk("idle timeout", a_busy, 1'b0);
   endtask
   task automatic start_a(input logic md, input logic [15:0] len);
      a_mode = md;
      a_blen = len;
      a_start = 1'b1;
      tick(1);
      a_start = 1'b0;
   endtask
   task automatic stop_a();
      a_stop = 1'b1;
      tick(1);
      a_stop = 1'b0;
      wait_idle(10);
      tick(2);
   endtask
   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int b0, d0;
      logic [63:0] hold;
      logic [15:0] seen;
      {a_en, a_mode, a_start, a_stop, a_sv, a_blen, a_sd, a_sch} = '0;
      {b_en, b_mode, b_start, b_stop, b_sv, b_blen, b_sd, b_sch} = '0;
      a_en = 1'b1;
      b_en = 1'b1;
      a_if.ready = 1'b0;
      b_if.ready = 1'b0;
      tick(2);
      chk("rst valid", a_if.valid, 1'b0);
      chk("rst data", a_if.data, 64'd0);
      chk("rst busy", a_busy, 1'b0);
      chk("rst done", a_done, 1'b0);
      chk("rst seed_ready", a_sr, 1'b0);
      rst = 1'b0;
      #1;
      chk("idle seed_ready", a_sr, 1'b1);
      tick(1);
      // free run: first beat carries the reset seeds
      a_if.ready = 1'b1;
      d0 = dones;
      start_a(1'b0, 16'd0);
      chk("busy after start", a_busy, 1'b1);
      chk("latency", a_if.valid, 1'b0);
      tick(1);
      chk("beat0 valid", a_if.valid, 1'b1);
      chk("beat0 word", a_if.data, 64'h670D_B386_59C3_ACE1);
      tick(1);
      chk("beat1 ch0", a_if.data[15:0], 16'h59C3);
      tick(3);
      stop_a();
      chk("free done", dones - d0, 1);
      // burst of three, then an empty burst
      b0 = beats;
      d0 = dones;
      start_a(1'b1, 16'd3);
      wait_idle(20);
      tick(2);
      chk("burst beats", beats - b0, 3);
      chk("burst done", dones - d0, 1);
      chk("burst busy", a_busy, 1'b0);
      b0 = beats;
      d0 = dones;
      start_a(1'b1, 16'd0);
      chk("len0 done", a_done, 1'b1);
      chk("len0 busy", a_busy, 1'b0);
      tick(1);
      chk("len0 pulse", a_done, 1'b0);
      tick(2);
      chk("len0 beats", beats - b0, 0);
      chk("len0 dones", dones - d0, 1);
      // backpressure, enable gating and a refused seed while busy
      start_a(1'b0, 16'd0);
      tick(4);
      a_if.ready = 1'b0;
      hold = a_if.data;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         chk("bp valid", a_if.valid, 1'b1);
         chk("bp stable", a_if.data, hold);
      end
      a_if.ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(1);
         chk("no gap", a_if.valid, 1'b1);
      end
      a_en = 1'b0;
      tick(1);
      chk("en0 beat drains", a_if.valid, 1'b0);
      tick(2);
      chk("en0 stays empty", a_if.valid, 1'b0);
      chk("en0 holds fsm", a_busy, 1'b1);
      a_en = 1'b1;
      tick(2);
      chk("en1 resumes", a_if.valid, 1'b1);
      a_sv = 1'b1;
      a_sch = 2'd0;
      a_sd = 16'h5555;
      #1;
      chk("busy seed_ready", a_sr, 1'b0);
      tick(1);
      a_sv = 1'b0;
      tick(3);
      stop_a();
      // zero seed reloads the channel seed; seed together with start
      a_sv = 1'b1;
      a_sch = 2'd2;
      a_sd = 16'h0000;
      tick(1);
      m[2] = rol(16'hACE1, 2);
      a_sch = 2'd1;
      a_sd = 16'h1234;
      a_mode = 1'b0;
      a_start = 1'b1;
      tick(1);
      m[1] = 16'h1234;
      a_sv = 1'b0;
      a_start = 1'b0;
      tick(1);
      chk("seed ch1", a_if.data[31:16], 16'h1234);
      chk("seed0 ch2", a_if.data[47:32], 16'hB386);
      tick(2);
      stop_a();
      // reset in the middle of a burst
      d0 = dones;
      start_a(1'b1, 16'd10);
      tick(3);
      rst = 1'b1;
      tick(1);
      chk("rst mid valid", a_if.valid, 1'b0);
      chk("rst mid busy", a_busy, 1'b0);
      chk("rst mid done", a_done, 1'b0);
      rst = 1'b0;
      tick(2);
      chk("rst no done", dones - d0, 0);
      start_a(1'b0, 16'd0);
      tick(1);
      chk("rst seeds", a_if.data, 64'h670D_B386_59C3_ACE1);
      stop_a();
      // narrow instance: out-of-range seed, then a full period on ch0
      b_sv = 1'b1;
      b_sch = 2'd3;
      b_sd = 4'h9;
      #1;
      chk("b seed_ready", b_sr, 1'b1);
      tick(1);
      b_sv = 1'b0;
      b_if.ready = 1'b1;
      b_start = 1'b1;
      tick(1);
      b_start = 1'b0;
      tick(1);
      chk("b seed nch", b_if.data, 12'h421);
      seen = '0;
      for (int k = 0; k < 16; k++) begin
         chk("b ch0 seq", b_if.data[3:0], seq[k]);
         if (k < 15) seen[b_if.data[3:0]] = 1'b1;
         tick(1);
      end
      chk("b distinct", $countones(seen), 15);
      b_stop = 1'b1;
      tick(1);
      b_stop = 1'b0;
      tick(3);
      chk("b idle", b_busy, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
